rr_grant_ctrl: RTL and testbench

Round-robin arbiter and grant sequencer that shares one datapath resource among N requesters. It produces a registered one-hot grant plus the matching binary index and valid flag, and holds a grant for as long as the owner keeps its request up. It sits between requesting engines and the shared unit, and uses the team's one-hot/binary conversion functions for index bookkeeping. An optional hold-limit counter forces rotation when an owner monopolises the resource.

---
 rtl/rr_grant_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rr_grant_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: registered one-hot grant, index and valid with rotating priority.
// Optional hold-limit preemption is compiled in with `define RR_GRANT_HOLD_LIMIT_EN.
module rr_grant_ctrl #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clk_en_i,
    input  logic [N-1:0]           req_i,
    output logic [N-1:0]           gnt_o,
    output logic [$clog2(N)-1:0]   gnt_idx_o,
    output logic                   gnt_vld_o,
    output logic                   preempt_o
);

    localparam int unsigned IDX_W = $clog2(N);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    if (N < 2 || MAX_HOLD < 1) begin : g_bad_cfg
        $error("rr_grant_ctrl: requires N >= 2 and MAX_HOLD >= 1");
    end

    function automatic logic [N-1:0] bin2oh(input logic [IDX_W-1:0] b);
        return N'(1) << b;
    endfunction

    function automatic logic [IDX_W-1:0] oh2bin(input logic [N-1:0] oh);
        logic [IDX_W-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (oh[IDX_W'(i)]) begin
                b = b | IDX_W'(i);
            end
        end
        return b;
    endfunction

    // Circular first-set search starting at p; returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] r, input logic [IDX_W-1:0] p);
        logic             found;
        logic [IDX_W-1:0] idx;
        int unsigned      j;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(p) + i) % N;
            if (!found && r[IDX_W'(j)]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        return {found, idx};
    endfunction

    logic [0:0]       state_q,   state_d;
    logic [IDX_W-1:0] ptr_q,     ptr_d;
    logic [IDX_W-1:0] owner_q,   owner_d;
    logic [N-1:0]     gnt_q,     gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic             preempt_q, preempt_d;

    logic [IDX_W-1:0] nxt_ptr_c;
    logic [N-1:0]     others_c;
    logic [IDX_W:0]   idle_pick_c;
    logic [IDX_W:0]   rot_pick_c;

`ifdef RR_GRANT_HOLD_LIMIT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_at_max_c;
    assign hold_at_max_c = (hold_cnt_q == HOLD_W'(MAX_HOLD));
`endif

    // The owner is excluded and sits last in the rotated order, so it never re-wins a handoff.
    assign nxt_ptr_c   = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + IDX_W'(1);
    assign others_c    = req_i & ~bin2oh(owner_q);
    assign idle_pick_c = rr_pick(req_i, ptr_q);
    assign rot_pick_c  = rr_pick(others_c, nxt_ptr_c);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        preempt_d = 1'b0;
`ifdef RR_GRANT_HOLD_LIMIT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (idle_pick_c[IDX_W]) begin
                    state_d = ST_BUSY;
                    owner_d = idle_pick_c[IDX_W-1:0];
                    gnt_d   = bin2oh(idle_pick_c[IDX_W-1:0]);
`ifdef RR_GRANT_HOLD_LIMIT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (!req_i[owner_q]) begin
                    ptr_d = nxt_ptr_c;
                    if (rot_pick_c[IDX_W]) begin
                        owner_d = rot_pick_c[IDX_W-1:0];
                        gnt_d   = bin2oh(rot_pick_c[IDX_W-1:0]);
`ifdef RR_GRANT_HOLD_LIMIT_EN
                        hold_cnt_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
`ifdef RR_GRANT_HOLD_LIMIT_EN
                else if (hold_at_max_c && rot_pick_c[IDX_W]) begin
                    ptr_d      = nxt_ptr_c;
                    owner_d    = rot_pick_c[IDX_W-1:0];
                    gnt_d      = bin2oh(rot_pick_c[IDX_W-1:0]);
                    hold_cnt_d = '0;
                    preempt_d  = 1'b1;
                end else if (!hold_at_max_c) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        // Index and valid are derived from the grant so all three always move together.
        gnt_idx_d = oh2bin(gnt_d);
        gnt_vld_d = |gnt_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            preempt_q <= 1'b0;
`ifdef RR_GRANT_HOLD_LIMIT_EN
            hold_cnt_q <= '0;
`endif
        end else if (clk_en_i) begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            preempt_q <= preempt_d;
`ifdef RR_GRANT_HOLD_LIMIT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end else begin
            preempt_q <= 1'b0;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = gnt_idx_q;
    assign gnt_vld_o = gnt_vld_q;
    assign preempt_o = preempt_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl (N=4, MAX_HOLD=4); hold-limit vectors follow RR_GRANT_HOLD_LIMIT_EN.
module tb_rr_grant_ctrl;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       preempt;

    typedef struct {
        logic [3:0] gnt;
        logic       pre;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    rr_grant_ctrl #(.N(4), .MAX_HOLD(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clk_en_i  (clk_en),
        .req_i     (req),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld),
        .preempt_o (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Apply one cycle of inputs and queue the response expected after the next rising edge.
    task automatic drive(input logic r, input logic en, input logic [3:0] rq,
                         input logic [3:0] eg, input logic ep, input string nm);
        exp_t e;
        @(negedge clk);
        rst    = r;
        clk_en = en;
        req    = rq;
        e.gnt  = eg;
        e.pre  = ep;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: one DUT response per rising edge, checked against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (gnt !== e.gnt || gnt_idx !== idx_of(e.gnt) ||
                    gnt_vld !== (|e.gnt) || preempt !== e.pre) begin
                    n_fail++;
                    $display("FAIL %s: got gnt=%b idx=%0d vld=%b preempt=%b, expected gnt=%b idx=%0d vld=%b preempt=%b",
                             e.name, gnt, gnt_idx, gnt_vld, preempt,
                             e.gnt, idx_of(e.gnt), |e.gnt, e.pre);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        clk_en = 1'b1;
        req    = 4'b0000;

        drive(1, 1, 4'b1111, 4'b0000, 0, "rst_hold0");
        drive(1, 1, 4'b1111, 4'b0000, 0, "rst_hold1");
        drive(0, 1, 4'b1111, 4'b0001, 0, "post_rst_grant0");
        drive(0, 1, 4'b0000, 4'b0000, 0, "release_to_idle");

        drive(0, 1, 4'b1010, 4'b0010, 0, "rot_first");
        drive(0, 1, 4'b1000, 4'b1000, 0, "rot_next3");
        drive(0, 1, 4'b0010, 4'b0010, 0, "rot_wrap1");

        for (int i = 0; i < 3; i++) drive(0, 0, 4'b0101, 4'b0010, 0, "freeze");
        drive(0, 1, 4'b0101, 4'b0100, 0, "unfreeze_switch");
        drive(0, 1, 4'b0011, 4'b0001, 0, "release_lowest_prio");

`ifdef RR_GRANT_HOLD_LIMIT_EN
        for (int i = 0; i < 4; i++) drive(0, 1, 4'b0101, 4'b0001, 0, "hold_keep");
        drive(0, 1, 4'b0101, 4'b0100, 1, "hold_preempt");
        drive(0, 1, 4'b0101, 4'b0100, 0, "preempt_single_pulse");
`else
        for (int i = 0; i < 20; i++) drive(0, 1, 4'b0101, 4'b0001, 0, "hold_no_limit");
`endif
        drive(0, 1, 4'b0000, 4'b0000, 0, "drop_all");

        drive(0, 1, 4'b0100, 4'b0100, 0, "grant2");
        drive(0, 1, 4'b1100, 4'b0100, 0, "hold2");
        drive(1, 1, 4'b1100, 4'b0000, 0, "rst_mid_grant");
        drive(0, 1, 4'b1100, 4'b0100, 0, "post_rst_ptr0");

        drive(0, 1, 4'b1000, 4'b1000, 0, "handoff3");
        drive(0, 1, 4'b0000, 4'b0000, 0, "single_drop");
        drive(0, 1, 4'b1000, 4'b1000, 0, "single_regrant");

        drive(1, 0, 4'b1000, 4'b0000, 0, "rst_while_disabled");
        drive(0, 0, 4'b1000, 4'b0000, 0, "disabled_idle");
        drive(0, 1, 4'b1000, 4'b1000, 0, "enabled_grant3");

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
